// File: rtl/usbf_cfg_pkg.sv
// Shared types for the USB function register-init sequencer: FSM states, table record, init contents.
// Pure declarations; no logic, no latency, no flow control.
package usbf_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_NEXT,
        ST_READY,
        ST_INT_RD,
        ST_INT_HOLD,
        ST_ERR
    } cfg_state_t;

    localparam int INT_SRC_ADDR_DEFAULT = 0;
    localparam int CFG_ADDR_W = 18;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [31:0]           data;
    } cfg_entry_t;

    // Bring-up image: control, endpoint configs, then interrupt mask last so
    // nothing fires before the endpoints are set up.
    function automatic cfg_entry_t cfg_rom_entry(input int idx);
        cfg_entry_t e;
        case (idx)
            0:       e = '{addr: 18'h0_0008, data: 32'h8000_0040};
            1:       e = '{addr: 18'h0_0010, data: 32'h0000_0200};
            2:       e = '{addr: 18'h0_0014, data: 32'h0000_0201};
            3:       e = '{addr: 18'h0_0018, data: 32'h0000_0102};
            4:       e = '{addr: 18'h0_001C, data: 32'h0000_0103};
            5:       e = '{addr: 18'h0_0020, data: 32'h0000_0000};
            6:       e = '{addr: 18'h0_0024, data: 32'h0000_0000};
            7:       e = '{addr: 18'h0_000C, data: 32'h0000_FFFF};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/usbf_cfg_rom.sv
// Init table: index -> Wishbone address/data, purely combinational (zero latency).
// No flow control; indices past NUM_ENTRIES read as zero.
module usbf_cfg_rom
    import usbf_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_W      = 18,
    parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data
);

    cfg_entry_t entry;

    always_comb begin
        entry = '0;
        if (int'(idx) < NUM_ENTRIES) begin
            entry = cfg_rom_entry(int'(idx));
        end
    end

    assign addr = ADDR_W'(entry.addr);
    assign data = entry.data;

endmodule

// File: rtl/usbf_cfg_seq.sv
// Register-init sequencer: walks the init table over Wishbone, then serves interrupt-source reads.
// One idle bus cycle after every ack; stalls on wb_ack_i (bounded by TIMEOUT) and on int_ready_i.
module usbf_cfg_seq
    import usbf_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES  = 8,
    parameter int ADDR_W       = 18,
    parameter int TIMEOUT      = 255,
    parameter int INT_SRC_ADDR = INT_SRC_ADDR_DEFAULT,
    parameter int IDX_W        = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              start_i,
    output logic [IDX_W-1:0]  tbl_idx_o,
    input  logic [ADDR_W-1:0] tbl_addr_i,
    input  logic [31:0]       tbl_data_i,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [31:0]       wb_data_o,
    input  logic [31:0]       wb_data_i,
    input  logic              wb_ack_i,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic              inta_i,
    output logic [31:0]       int_src_o,
    output logic              int_valid_o,
    input  logic              int_ready_i,
    output logic              done_o,
    output logic              err_o
);

    localparam int               TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

    cfg_state_t       state;
    logic             bus;
    logic             we;
    logic [TMO_W-1:0] tmo;
    logic             restart;

    // Restart is only honoured between bus cycles so a transfer is never cut short.
    assign restart = start_i && (state == ST_IDLE || state == ST_READY ||
                                 state == ST_INT_HOLD || state == ST_ERR);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state       <= ST_IDLE;
            bus         <= 1'b0;
            we          <= 1'b0;
            tmo         <= '0;
            tbl_idx_o   <= '0;
            int_src_o   <= '0;
            int_valid_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else if (restart) begin
            state       <= ST_WR;
            bus         <= 1'b1;
            we          <= 1'b1;
            tmo         <= '0;
            tbl_idx_o   <= '0;
            int_valid_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                ST_WR, ST_INT_RD: begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    if (wb_ack_i) begin
                        bus <= 1'b0;
                        we  <= 1'b0;
                        if (state == ST_WR) begin
                            state <= ST_NEXT;
                        end else begin
                            int_src_o   <= wb_data_i;
                            int_valid_o <= 1'b1;
                            state       <= ST_INT_HOLD;
                        end
                    end else if (tmo == TMO_MAX) begin
                        bus   <= 1'b0;
                        we    <= 1'b0;
                        err_o <= 1'b1;
                        state <= ST_ERR;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (tbl_idx_o == IDX_LAST) begin
                        done_o <= 1'b1;
                        state  <= ST_READY;
                    end else begin
                        tbl_idx_o <= tbl_idx_o + 1'b1;
                        bus       <= 1'b1;
                        we        <= 1'b1;
                        tmo       <= '0;
                        state     <= ST_WR;
                    end
                end
                ST_READY: begin
                    if (inta_i) begin
                        bus   <= 1'b1;
                        we    <= 1'b0;
                        tmo   <= '0;
                        state <= ST_INT_RD;
                    end
                end
                ST_INT_HOLD: begin
                    if (int_ready_i) begin
                        int_valid_o <= 1'b0;
                        state       <= ST_READY;
                    end
                end
                ST_IDLE, ST_ERR: begin
                    state <= state;
                end
                default: begin
                    bus   <= 1'b0;
                    we    <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_cyc_o = bus;
    assign wb_stb_o = bus;
    assign wb_we_o  = we;

    // Address/data follow the table index register through the ROM, so a
    // restart that zeroes the index presents entry 0 in the first WR cycle.
    always_comb begin
        wb_addr_o = '0;
        wb_data_o = '0;
        if (state == ST_WR) begin
            wb_addr_o = tbl_addr_i;
            wb_data_o = tbl_data_i;
        end else if (state == ST_INT_RD) begin
            wb_addr_o = ADDR_W'(INT_SRC_ADDR);
        end
    end

endmodule

// File: tb/tb_usbf_cfg_seq.sv
// Directed bench for usbf_cfg_seq with the init ROM instantiated beside it.
// A negedge-driven Wishbone slave logs every acked transfer for the scenario tasks.
module tb_usbf_cfg_seq;

    localparam int NE  = 3;
    localparam int AW  = 18;
    localparam int TO  = 255;
    localparam int ISA = 'h30;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    tbl_idx;
    logic [AW-1:0] tbl_addr;
    logic [31:0]   tbl_data;
    logic [AW-1:0] wb_addr;
    logic [31:0]   wb_dat_o;
    logic [31:0]   wb_dat_i;
    logic          wb_ack;
    logic          wb_we, wb_stb, wb_cyc;
    logic          inta = 1'b0;
    logic [31:0]   int_src;
    logic          int_valid;
    logic          int_ready = 1'b0;
    logic          done, err;

    int checks = 0;
    int failures = 0;
    int cyc_num = 0;

    logic [AW-1:0] exp_addr [3] = '{18'h0_0008, 18'h0_0010, 18'h0_0014};
    logic [31:0]   exp_data [3] = '{32'h8000_0040, 32'h0000_0200, 32'h0000_0201};

    // slave controls and monitors
    bit          ack_en = 1'b1;
    int          ack_dly = 2;
    int          no_ack_idx = -1;
    logic [31:0] rd_data = 32'h0;
    int          wait_cnt = 0;
    bit          ack_prev = 1'b0;
    int          mon_cycstb = 0, mon_rddata = 0, mon_gap = 0;
    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];
    logic          log_we[$];
    logic          log_done[$];
    int            log_cyc[$];

    usbf_cfg_seq #(.NUM_ENTRIES(NE), .ADDR_W(AW), .TIMEOUT(TO), .INT_SRC_ADDR(ISA)) dut (
        .clk_i(clk), .nrst_i(nrst), .start_i(start),
        .tbl_idx_o(tbl_idx), .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data),
        .wb_addr_o(wb_addr), .wb_data_o(wb_dat_o), .wb_data_i(wb_dat_i), .wb_ack_i(wb_ack),
        .wb_we_o(wb_we), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc),
        .inta_i(inta), .int_src_o(int_src), .int_valid_o(int_valid), .int_ready_i(int_ready),
        .done_o(done), .err_o(err)
    );

    usbf_cfg_rom #(.NUM_ENTRIES(NE), .ADDR_W(AW)) rom (
        .idx(tbl_idx), .addr(tbl_addr), .data(tbl_data)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc_num++;
    end

    initial begin
        wb_ack = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (wb_cyc !== wb_stb) mon_cycstb++;
            if (wb_cyc === 1'b1 && wb_we === 1'b0 && wb_dat_o !== 32'h0) mon_rddata++;
            if (ack_prev && wb_cyc === 1'b1) mon_gap++;
            if (wb_cyc === 1'b1 && ack_en && wait_cnt == ack_dly &&
                !(wb_we === 1'b1 && int'(tbl_idx) == no_ack_idx)) begin
                wb_ack = 1'b1;
                wb_dat_i = (wb_we === 1'b1) ? 32'h0 : rd_data;
                log_addr.push_back(wb_addr);
                log_data.push_back(wb_dat_o);
                log_we.push_back(wb_we);
                log_done.push_back(done);
                log_cyc.push_back(cyc_num);
            end else begin
                wb_ack = 1'b0;
                wb_dat_i = 32'h0;
            end
            ack_prev = wb_ack;
            wait_cnt = (wb_cyc === 1'b1) ? wait_cnt + 1 : 0;
        end
    end

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_we.delete(); log_done.delete(); log_cyc.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_for(input int what, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            case (what)
                0:       ok = (done === 1'b1);
                1:       ok = (int_valid === 1'b1);
                2:       ok = (tbl_idx === 2'd1 && wb_cyc === 1'b1);
                3:       ok = (wb_cyc === 1'b0);
                default: ok = (err === 1'b1);
            endcase
        end
    endtask

    task automatic test_reset();
        #1 nrst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin failures++; $display("FAIL rst_strobes got=%b exp=000", {wb_cyc, wb_stb, wb_we}); end
        checks++; if (wb_addr !== '0) begin failures++; $display("FAIL rst_addr got=%h exp=0", wb_addr); end
        checks++; if (wb_dat_o !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", wb_dat_o); end
        checks++; if (tbl_idx !== 2'd0) begin failures++; $display("FAIL rst_idx got=%0d exp=0", tbl_idx); end
        checks++; if (int_src !== 32'h0) begin failures++; $display("FAIL rst_int_src got=%h exp=0", int_src); end
        checks++; if ({int_valid, done, err} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {int_valid, done, err}); end
        @(negedge clk) nrst = 1'b1;
    endtask

    task automatic test_walk();
        bit ok;
        int done_c;
        clear_log();
        pulse_start();
        wait_for(0, 100, ok);
        done_c = cyc_num;
        checks++; if (!ok) begin failures++; $display("FAIL walk_done_wait timed out done=%b", done); end
        checks++; if (log_addr.size() != 3) begin failures++; $display("FAIL walk_count got=%0d exp=3", log_addr.size()); end
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i] || log_we[i] !== 1'b1) begin
                failures++;
                $display("FAIL walk_entry%0d got=%h/%h we=%b exp=%h/%h we=1", i, log_addr[i], log_data[i], log_we[i], exp_addr[i], exp_data[i]);
            end
        end
        if (log_cyc.size() == 3) begin
            checks++; if (log_cyc[1] - log_cyc[0] != 4 || log_cyc[2] - log_cyc[1] != 4) begin failures++; $display("FAIL walk_spacing got=%0d,%0d exp=4,4", log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1]); end
            checks++; if (log_done[2] !== 1'b0) begin failures++; $display("FAIL walk_done_early got=%b exp=0", log_done[2]); end
            checks++; if (done_c - log_cyc[2] != 2) begin failures++; $display("FAIL walk_done_lat got=%0d exp=2", done_c - log_cyc[2]); end
        end
        checks++; if ({err, tbl_idx} !== 3'b010) begin failures++; $display("FAIL walk_final err/idx got=%b/%0d exp=0/2", err, tbl_idx); end
    endtask

    task automatic test_int();
        bit ok;
        bit stable = 1'b1;
        clear_log();
        rd_data = 32'h0000_0104;
        @(negedge clk) inta = 1'b1;
        wait_for(1, 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL int_valid_wait timed out int_valid=%b", int_valid); end
        checks++; if (log_addr.size() != 1) begin failures++; $display("FAIL int_rd_count got=%0d exp=1", log_addr.size()); end
        if (log_addr.size() > 0) begin
            checks++; if (log_addr[0] !== 18'h0_0030 || log_we[0] !== 1'b0) begin failures++; $display("FAIL int_rd_addr got=%h we=%b exp=00030 we=0", log_addr[0], log_we[0]); end
        end
        checks++; if (int_src !== 32'h0000_0104) begin failures++; $display("FAIL int_src got=%h exp=00000104", int_src); end
        repeat (20) begin
            @(negedge clk);
            if (int_valid !== 1'b1 || int_src !== 32'h0000_0104 || wb_cyc !== 1'b0) stable = 1'b0;
        end
        checks++; if (!stable) begin failures++; $display("FAIL int_hold got=unstable exp=valid,stable,no bus"); end
        checks++; if (log_addr.size() != 1) begin failures++; $display("FAIL int_no_second_rd got=%0d exp=1", log_addr.size()); end
        inta = 1'b0;
        int_ready = 1'b1;
        @(negedge clk) int_ready = 1'b0;
        checks++; if (int_valid !== 1'b0) begin failures++; $display("FAIL int_release got=%b exp=0", int_valid); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL int_done_kept got=%b exp=1", done); end
    endtask

    task automatic test_start_in_wr();
        bit ok;
        clear_log();
        pulse_start();
        checks++; if ({wb_cyc, done, tbl_idx} !== 4'b1000) begin failures++; $display("FAIL restart_ready cyc/done/idx got=%b/%b/%0d exp=1/0/0", wb_cyc, done, tbl_idx); end
        wait_for(2, 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL swr_idx1_wait timed out idx=%0d", tbl_idx); end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_for(0, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL swr_done_wait timed out done=%b", done); end
        checks++; if (log_addr.size() != 3) begin failures++; $display("FAIL swr_count got=%0d exp=3", log_addr.size()); end
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                failures++;
                $display("FAIL swr_entry%0d got=%h/%h exp=%h/%h", i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_ack_at_timeout();
        bit ok;
        clear_log();
        ack_dly = 255;
        pulse_start();
        wait_for(0, 1200, ok);
        ack_dly = 2;
        checks++; if (!ok) begin failures++; $display("FAIL late_done_wait timed out done=%b err=%b", done, err); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL late_err got=%b exp=0", err); end
        checks++; if (log_addr.size() != 3) begin failures++; $display("FAIL late_count got=%0d exp=3", log_addr.size()); end
        if (log_cyc.size() == 3) begin
            checks++; if (log_cyc[1] - log_cyc[0] != 257 || log_addr[2] !== exp_addr[2]) begin failures++; $display("FAIL late_spacing got=%0d/%h exp=257/%h", log_cyc[1] - log_cyc[0], log_addr[2], exp_addr[2]); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int t0, t1;
        clear_log();
        no_ack_idx = 1;
        pulse_start();
        wait_for(2, 50, ok);
        t0 = cyc_num;
        checks++; if (!ok) begin failures++; $display("FAIL to_idx1_wait timed out idx=%0d", tbl_idx); end
        wait_for(3, 400, ok);
        t1 = cyc_num;
        checks++; if (!ok) begin failures++; $display("FAIL to_drop_wait timed out cyc=%b", wb_cyc); end
        checks++; if (t1 - t0 != 256) begin failures++; $display("FAIL to_cycles got=%0d exp=256", t1 - t0); end
        checks++; if ({err, done} !== 2'b10) begin failures++; $display("FAIL to_flags err/done got=%b/%b exp=1/0", err, done); end
        checks++; if (tbl_idx !== 2'd1 || log_addr.size() != 1) begin failures++; $display("FAIL to_progress idx/writes got=%0d/%0d exp=1/1", tbl_idx, log_addr.size()); end
        repeat (5) @(negedge clk);
        checks++; if (err !== 1'b1 || wb_cyc !== 1'b0) begin failures++; $display("FAIL to_err_hold err/cyc got=%b/%b exp=1/0", err, wb_cyc); end
        no_ack_idx = -1;
        clear_log();
        pulse_start();
        checks++; if ({err, wb_cyc, tbl_idx} !== 4'b0100) begin failures++; $display("FAIL to_restart err/cyc/idx got=%b/%b/%0d exp=0/1/0", err, wb_cyc, tbl_idx); end
        wait_for(0, 100, ok);
        checks++; if (!ok || log_addr.size() != 3) begin failures++; $display("FAIL to_rewalk done/writes got=%b/%0d exp=1/3", done, log_addr.size()); end
        if (log_addr.size() > 0) begin
            checks++; if (log_addr[0] !== exp_addr[0]) begin failures++; $display("FAIL to_rewalk_first got=%h exp=%h", log_addr[0], exp_addr[0]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit idle_ok = 1'b1;
        clear_log();
        pulse_start();
        wait_for(2, 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rm_idx1_wait timed out idx=%0d", tbl_idx); end
        nrst = 1'b0;
        #1;
        checks++; if ({wb_cyc, wb_stb, done} !== 3'b000) begin failures++; $display("FAIL rm_async cyc/stb/done got=%b exp=000", {wb_cyc, wb_stb, done}); end
        checks++; if (tbl_idx !== 2'd0) begin failures++; $display("FAIL rm_idx got=%0d exp=0", tbl_idx); end
        @(negedge clk) nrst = 1'b1;
        inta = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (wb_cyc !== 1'b0 || tbl_idx !== 2'd0 || done !== 1'b0 || err !== 1'b0 || int_valid !== 1'b0) idle_ok = 1'b0;
        end
        inta = 1'b0;
        checks++; if (!idle_ok) begin failures++; $display("FAIL rm_idle got=activity exp=idle until start"); end
        checks++; if (log_addr.size() != 1) begin failures++; $display("FAIL rm_writes got=%0d exp=1", log_addr.size()); end
        clear_log();
        pulse_start();
        wait_for(0, 100, ok);
        checks++; if (!ok || log_addr.size() != 3) begin failures++; $display("FAIL rm_rewalk done/writes got=%b/%0d exp=1/3", done, log_addr.size()); end
    endtask

    task automatic test_bus_rules();
        checks++; if (mon_cycstb != 0) begin failures++; $display("FAIL cyc_eq_stb violations got=%0d exp=0", mon_cycstb); end
        checks++; if (mon_rddata != 0) begin failures++; $display("FAIL read_data_zero violations got=%0d exp=0", mon_rddata); end
        checks++; if (mon_gap != 0) begin failures++; $display("FAIL idle_gap violations got=%0d exp=0", mon_gap); end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_int();
        test_start_in_wr();
        test_ack_at_timeout();
        test_timeout();
        test_reset_mid();
        test_bus_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usbf_cfg_seq.md
USBF_CFG_SEQ -- requirements
Module: usbf_cfg_seq

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8: number of register-init table entries.
REQ-002 SHALL have parameter ADDR_W, default 18: Wishbone address width.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for wb_ack_i per transaction.
REQ-004 SHALL have parameter INT_SRC_ADDR, default 0: address of the core interrupt-source register.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; nrst_i  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports:
- start_i  in  1  pulse, (re)start table walk
- tbl_idx_o  out  clog2(NUM_ENTRIES)  table index
- tbl_addr_i  in  ADDR_W  entry address, combinational from index
- tbl_data_i  in  32  entry data
- wb_addr_o  out  ADDR_W
- wb_data_o  out  32
- wb_data_i  in  32
- wb_ack_i  in  1
- wb_we_o  out  1
- wb_stb_o  out  1
- wb_cyc_o  out  1
- inta_i  in  1  level interrupt from the USB core
- int_src_o  out  32  captured interrupt source
- int_valid_o  out  1
- int_ready_i  in  1
- done_o  out  1  table written
- err_o  out  1  ack timeout

Function
REQ-007 SHALL implement the states IDLE, WR, NEXT, READY, INT_RD, INT_HOLD and ERR.
REQ-008 IDLE SHALL move to WR on start_i; all other inputs are ignored in IDLE.
REQ-009 WR SHALL hold cyc=stb=we=1 with wb_addr_o/wb_data_o from the table at tbl_idx_o until wb_ack_i is sampled high.
REQ-010 WR SHALL drop cyc/stb in the cycle after the ack and enter NEXT, so each transfer is followed by at least one idle bus cycle.
REQ-011 NEXT SHALL increment tbl_idx_o; if the index equals NUM_ENTRIES-1, NEXT SHALL instead set done_o and enter READY; otherwise it SHALL return to WR.
REQ-012 READY with inta_i=1 SHALL enter INT_RD and perform a read at INT_SRC_ADDR (we=0).
REQ-013 INT_RD SHALL capture wb_data_i into int_src_o in the ack cycle.
REQ-014 INT_HOLD SHALL assert int_valid_o with int_src_o stable until int_ready_i=1, then return to READY; while int_valid_o is high, no new read SHALL be issued, even with inta_i high.
REQ-015 A timeout counter SHALL clear when each transaction starts and count every WR/INT_RD cycle without an ack.
REQ-016 When the timeout counter reaches TIMEOUT, the block SHALL drop cyc/stb in the next cycle, set err_o, and enter ERR.
REQ-017 ERR SHALL hold err_o=1; start_i in ERR SHALL clear err_o and done_o, reset the index to 0, and enter WR.
REQ-018 start_i in READY or INT_HOLD SHALL clear done_o and int_valid_o, reset the index, and enter WR. start_i during WR/INT_RD SHALL be ignored, so a bus cycle is never aborted.
REQ-019 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-020 wb_cyc_o SHALL always equal wb_stb_o.
REQ-021 wb_data_o SHALL be 0 during reads.

Reset
REQ-022 On nrst_i=0, the block SHALL enter IDLE asynchronously.
REQ-023 On reset, all outputs SHALL go to 0: wb_* strobes, address, data, tbl_idx_o, int_src_o, int_valid_o, done_o, err_o and the timeout counter.
REQ-024 Reset asserted mid-transaction SHALL drop cyc/stb immediately; no partial state is retained.

Structure
REQ-025 The FSM state encoding, the default INT_SRC_ADDR, and a table-entry record type (addr, data) SHALL live in the shared package usbf_cfg_pkg.
REQ-026 The init table SHALL be the sub-module usbf_cfg_rom (index -> addr/data, combinational), instantiated beside the sequencer rather than inside it.

Verification
REQ-027 Bench SHALL cover: NUM_ENTRIES=3, start_i pulse, slave acks after 2 cycles -> three writes in index order, each with an idle cycle between them; done_o=1 after the third ack.
REQ-028 Bench SHALL cover: slave never acks on entry 1 with TIMEOUT=255 -> cyc drops 256 cycles after entry 1 starts; err_o=1; done_o=0. A later start_i restarts at index 0.
REQ-029 Bench SHALL cover: in READY, inta_i=1 with the slave returning 32'h0000_0104 -> read at INT_SRC_ADDR; int_src_o=32'h0000_0104 with int_valid_o held until int_ready_i; no second read while waiting.
REQ-030 Bench SHALL cover: nrst_i pulsed low during the second write -> cyc/stb/done_o go to 0 at once; the block stays in IDLE until start_i.
REQ-031 Bench SHALL cover: ack in the same cycle the counter reaches TIMEOUT -> err_o stays 0 and the walk continues.
REQ-032 Bench SHALL cover: start_i during WR -> the current write completes unchanged and the walk is not restarted.
